// File: rtl/line_buf_3x3_ctrl.sv
// Frame/line sequencer for the 3x3 line-shift window generator: tracks pixel
// position, gates the line-buffer write enable and flags populated windows.
module line_buf_3x3_ctrl #(
  parameter int IMG_W_MAX = 1936,
  parameter int IMG_H_MAX = 1096,
  parameter int CNT_W     = 11
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  output logic             buf_clken,
  output logic             buf_addr_clr,
  output logic [CNT_W-1:0] col_cnt,
  output logic [CNT_W-1:0] row_cnt,
  output logic             win_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic [CNT_W-1:0] line_len,
  output logic             err_ovf,
  output logic             err_len
);

  localparam logic [CNT_W-1:0] W_MAX  = CNT_W'(IMG_W_MAX);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(IMG_H_MAX - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);

  typedef enum logic [1:0] {IDLE, FWAIT, LINE} state_t;

  state_t           state_q, state_d;
  logic             vs_r_q, hr_r_q;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             elen_q, elen_d;
  logic [CNT_W-1:0] col_out_q, col_out_d;
  logic [CNT_W-1:0] row_out_q, row_out_d;
  logic             clken_q;
  logic [2:0]       win_pipe_q;
  logic [1:0]       fs_pipe_q, fd_pipe_q, clr_pipe_q;

  logic vs_rise, hr_rise, hr_fall;
  logic accept, restart, fdone_evt, clr_evt, win_evt;

  assign vs_rise = per_frame_vsync & ~vs_r_q;
  assign hr_rise = per_frame_href  & ~hr_r_q;
  assign hr_fall = ~per_frame_href & hr_r_q;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    elen_d    = elen_q;
    restart   = 1'b0;
    fdone_evt = 1'b0;
    clr_evt   = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (vs_rise) restart = 1'b1;
      end
      FWAIT: begin
        if (vs_rise) begin
          restart   = 1'b1;
          fdone_evt = (row_q != '0);
        end else if (hr_rise) begin
          state_d = LINE;
          clr_evt = 1'b1;
        end
      end
      LINE: begin
        if (vs_rise) begin
          // aborted line: neither counted as a row nor length-checked
          restart   = 1'b1;
          fdone_evt = (row_q != '0);
        end else begin
          if (per_frame_href && per_frame_clken) begin
            if (col_q < W_MAX) begin
              accept = 1'b1;
              col_d  = col_q + ONE;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (hr_fall) begin
            state_d = FWAIT;
            if (row_q == '0) len_d = col_q;
            else if (col_q != len_q) elen_d = 1'b1;
            col_d = '0;
            // past the last row keep overwriting it rather than wrapping
            if (row_q == H_LAST) begin
              ovf_d = 1'b1;
              row_d = H_LAST;
            end else begin
              row_d = row_q + ONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d = FWAIT;
      col_d   = '0;
      row_d   = '0;
      len_d   = '0;
      ovf_d   = 1'b0;
      elen_d  = 1'b0;
    end
  end

  assign win_evt = accept && (row_q >= TWO) && (col_q >= TWO);

  // row_cnt keeps the finished frame's row through the frame_done pulse
  always_comb begin
    col_out_d = col_out_q;
    row_out_d = row_q;
    if (restart) col_out_d = '0;
    else if (accept) col_out_d = col_q;
    if (restart || fs_pipe_q[0]) row_out_d = row_out_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vs_r_q     <= 1'b0;
      hr_r_q     <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      elen_q     <= 1'b0;
      col_out_q  <= '0;
      row_out_q  <= '0;
      clken_q    <= 1'b0;
      win_pipe_q <= '0;
      fs_pipe_q  <= '0;
      fd_pipe_q  <= '0;
      clr_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      vs_r_q     <= per_frame_vsync;
      hr_r_q     <= per_frame_href;
      col_q      <= col_d;
      row_q      <= row_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      elen_q     <= elen_d;
      col_out_q  <= col_out_d;
      row_out_q  <= row_out_d;
      clken_q    <= accept;
      win_pipe_q <= {win_pipe_q[1:0], win_evt};
      fs_pipe_q  <= {fs_pipe_q[0], restart};
      fd_pipe_q  <= {fd_pipe_q[0], fdone_evt};
      clr_pipe_q <= {clr_pipe_q[0], clr_evt};
    end
  end

  assign buf_clken    = clken_q;
  assign buf_addr_clr = clr_pipe_q[1];
  assign col_cnt      = col_out_q;
  assign row_cnt      = row_out_q;
  assign win_valid    = win_pipe_q[2];
  assign frame_start  = fs_pipe_q[1];
  assign frame_done   = fd_pipe_q[1];
  assign line_len     = len_q;
  assign err_ovf      = ovf_q;
  assign err_len      = elen_q;

endmodule

// File: tb/tb_line_buf_3x3_ctrl.sv
// Bench for line_buf_3x3_ctrl: table of frame scenarios, hand-written corner
// sequences and random frames, scored against a per-pixel/per-frame model.
module tb_line_buf_3x3_ctrl;
  localparam int WM = 16;
  localparam int HM = 6;
  localparam int CW = 11;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  logic vsync = 1'b0, href = 1'b0, clken = 1'b0;
  logic buf_clken, buf_addr_clr, win_valid, frame_start, frame_done, err_ovf, err_len;
  logic [CW-1:0] col_cnt, row_cnt, line_len;

  always #5 clock = ~clock;

  line_buf_3x3_ctrl #(.IMG_W_MAX(WM), .IMG_H_MAX(HM), .CNT_W(CW)) dut (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .buf_clken(buf_clken), .buf_addr_clr(buf_addr_clr),
    .col_cnt(col_cnt), .row_cnt(row_cnt), .win_valid(win_valid),
    .frame_start(frame_start), .frame_done(frame_done), .line_len(line_len),
    .err_ovf(err_ovf), .err_len(err_len)
  );

  typedef struct {int col; int row; bit win;} px_t;
  typedef struct {
    int h; int w; int short_row; int short_w; int per;
    int px; int win; int len; bit elen; bit eovf;
  } vec_t;

  px_t exp_q[$];
  int  n_chk = 0, n_pass = 0;
  int  cnt_px = 0, cnt_clr = 0, cnt_win = 0, cnt_fs = 0, cnt_fd = 0, fd_row = 0;
  bit [1:0] win_sh = 2'b00;
  int  line_w[16];
  int  prev_h = 0;
  int  fr_px, fr_clr, fr_win;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Per-frame expectations from line widths: accepted pixels, windows, errors.
  function automatic void model(input int n, output int px, output int win,
                                output int len, output bit elen, output bit eovf);
    int a, rr;
    px = 0; win = 0; len = 0; elen = 0; eovf = 0;
    for (int r = 0; r < n; r++) begin
      a  = (line_w[r] < WM) ? line_w[r] : WM;
      rr = (r < HM) ? r : HM - 1;
      px += a;
      if (rr >= 2 && a > 2) win += a - 2;
      if (r == 0) len = a;
      else if (a != len) elen = 1;
      if (line_w[r] > WM) eovf = 1;
      if (r + 1 >= HM) eovf = 1;
    end
  endfunction

  // Monitor: scoreboard every written pixel, expect win_valid two cycles later.
  always @(negedge clock) begin
    px_t e;
    bit  f;
    f = 1'b0;
    if (buf_clken === 1'b1) begin
      cnt_px++;
      chk("sb_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("col_cnt", col_cnt, e.col);
        chk("row_cnt", row_cnt, e.row);
        f = e.win;
      end
    end
    if (win_sh[1] || win_valid === 1'b1) chk("win_valid", win_valid, win_sh[1]);
    win_sh = {win_sh[0], f};
    if (buf_addr_clr === 1'b1) cnt_clr++;
    if (win_valid === 1'b1) cnt_win++;
    if (frame_start === 1'b1) cnt_fs++;
    if (frame_done === 1'b1) begin cnt_fd++; fd_row = row_cnt; end
  end

  task automatic drive_line(input int r, input int w, input int per, input int stop_at);
    px_t it;
    href = 1'b1; clken = 1'b0;
    tick(2);
    for (int p = 0; p < w; p++) begin
      clken = 1'b0;
      if (per > 1) tick(per - 1);
      if (p == stop_at) begin
        vsync = 1'b1; clken = 1'b1; tick();
        clken = 1'b0; tick();
        vsync = 1'b0; tick();
        href = 1'b0;
        return;
      end
      clken = 1'b1;
      if (p < WM) begin
        it.col = p;
        it.row = (r < HM) ? r : HM - 1;
        it.win = (it.row >= 2) && (p >= 2);
        exp_q.push_back(it);
      end
      tick();
    end
    clken = 1'b0; href = 1'b0;
    tick(4);
  endtask

  // Frame boundary: checks closing of the previous frame and the new start.
  task automatic vs_pulse_chk();
    int b_fs, b_fd;
    b_fs = cnt_fs; b_fd = cnt_fd;
    vsync = 1'b1; tick(2);
    vsync = 1'b0; tick(3);
    chk("frame_start_cnt", cnt_fs - b_fs, 1);
    chk("frame_done_cnt", cnt_fd - b_fd, (prev_h > 0) ? 1 : 0);
    if (prev_h > 0) chk("frame_done_row", fd_row, (prev_h < HM) ? prev_h : HM - 1);
    chk("err_cleared", {err_len, err_ovf}, 0);
    chk("line_len_cleared", line_len, 0);
    chk("row_cnt_cleared", row_cnt, 0);
  endtask

  task automatic run_frame(input int h, input int per);
    int b_px, b_clr, b_win, px, win, len, lw;
    bit elen, eovf;
    vs_pulse_chk();
    b_px = cnt_px; b_clr = cnt_clr; b_win = cnt_win;
    for (int r = 0; r < h; r++) begin
      drive_line(r, line_w[r], per, -1);
      model(r + 1, px, win, len, elen, eovf);
      chk("err_len_line", err_len, elen);
      chk("err_ovf_line", err_ovf, eovf);
    end
    tick(3);
    fr_px = cnt_px - b_px; fr_clr = cnt_clr - b_clr; fr_win = cnt_win - b_win;
    lw = (line_w[h-1] < WM) ? line_w[h-1] : WM;
    chk("sb_drained", exp_q.size(), 0);
    chk("addr_clr_cnt", fr_clr, h);
    chk("col_cnt_final", col_cnt, lw - 1);
    chk("row_cnt_final", row_cnt, (h < HM) ? h : HM - 1);
    prev_h = h;
  endtask

  initial begin
    vec_t tbl[5];
    int b_px, b_clr, b_fs, b_fd, h, per, w0, px, win, len;
    bit elen, eovf;

    //            h  w  srow sw per  px win len elen eovf
    tbl[0] = '{4,  8, -1,  0, 1, 32, 12,  8, 0, 0};
    tbl[1] = '{3, 16, -1,  0, 3, 48, 14, 16, 0, 0};
    tbl[2] = '{4, 12,  2, 11, 1, 47, 19, 12, 1, 0};
    tbl[3] = '{3, 20, -1,  0, 1, 48, 14, 16, 0, 1};
    tbl[4] = '{8,  4, -1,  0, 2, 32, 12,  4, 0, 1};

    #2 rst_n = 1'b0;
    tick(3);
    chk("reset_outputs", {buf_clken, buf_addr_clr, col_cnt, row_cnt, win_valid,
                          frame_start, frame_done, line_len, err_ovf, err_len}, 0);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < tbl[i].h; r++)
        line_w[r] = (r == tbl[i].short_row) ? tbl[i].short_w : tbl[i].w;
      run_frame(tbl[i].h, tbl[i].per);
      chk("tbl_px", fr_px, tbl[i].px);
      chk("tbl_win", fr_win, tbl[i].win);
      chk("tbl_line_len", line_len, tbl[i].len);
      chk("tbl_err_len", err_len, tbl[i].elen);
      chk("tbl_err_ovf", err_ovf, tbl[i].eovf);
    end

    // vsync arrives at pixel 5 of row 3
    for (int r = 0; r < 4; r++) line_w[r] = 12;
    run_frame(3, 1);
    b_fs = cnt_fs; b_fd = cnt_fd;
    drive_line(3, 12, 1, 5);
    tick(3);
    chk("abort_frame_done", cnt_fd - b_fd, 1);
    chk("abort_done_row", fd_row, 3);
    chk("abort_frame_start", cnt_fs - b_fs, 1);
    chk("abort_row_cnt", row_cnt, 0);
    chk("abort_col_cnt", col_cnt, 0);
    chk("abort_err_len", err_len, 0);
    chk("abort_sb", exp_q.size(), 0);
    prev_h = 0;
    run_frame(3, 2);
    chk("post_abort_px", fr_px, 36);

    // reset during row 1, released mid-frame
    for (int r = 0; r < 3; r++) line_w[r] = 8;
    vs_pulse_chk();
    drive_line(0, 8, 1, -1);
    href = 1'b1; tick(2);
    for (int p = 0; p < 3; p++) begin
      clken = 1'b1;
      exp_q.push_back('{p, 1, 1'b0});
      tick();
    end
    clken = 1'b0; tick(5);
    rst_n = 1'b0; #1;
    chk("midrst_outputs", {buf_clken, buf_addr_clr, col_cnt, row_cnt, win_valid,
                           frame_start, frame_done, line_len, err_ovf, err_len}, 0);
    tick(2);
    chk("midrst_outputs_hold", {buf_clken, buf_addr_clr, col_cnt, row_cnt, win_valid,
                                frame_start, frame_done, line_len, err_ovf, err_len}, 0);
    rst_n = 1'b1; tick(3);
    href = 1'b0; tick(3);
    b_px = cnt_px; b_clr = cnt_clr; b_fs = cnt_fs; b_fd = cnt_fd;
    href = 1'b1; tick(2);
    clken = 1'b1; tick(6);
    clken = 1'b0; href = 1'b0; tick(4);
    chk("idle_px_ignored", cnt_px - b_px, 0);
    chk("idle_clr_ignored", cnt_clr - b_clr, 0);
    chk("idle_no_pulses", (cnt_fs - b_fs) + (cnt_fd - b_fd), 0);
    chk("idle_sb", exp_q.size(), 0);
    prev_h = 0;
    run_frame(3, 1);
    chk("post_rst_px", fr_px, 24);
    chk("post_rst_win", fr_win, 6);
    chk("post_rst_len", line_len, 8);

    // random frames
    for (int k = 0; k < 8; k++) begin
      h   = $urandom_range(1, 7);
      per = $urandom_range(1, 3);
      w0  = $urandom_range(3, 20);
      for (int r = 0; r < h; r++)
        line_w[r] = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 20) : w0;
      run_frame(h, per);
      model(h, px, win, len, elen, eovf);
      chk("rnd_px", fr_px, px);
      chk("rnd_win", fr_win, win);
      chk("rnd_line_len", line_len, len);
      chk("rnd_err_len", err_len, elen);
      chk("rnd_err_ovf", err_ovf, eovf);
    end

    vs_pulse_chk();
    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/line_buf_3x3_ctrl.md
# line_buf_3x3_ctrl

Frame and line sequencer for the 3x3 line-shift RAM window generator in the VIP pipeline. It sits between the camera/ISP pixel timing signals and the line buffer. It tracks column and row position and gates the line-buffer clock enable to active pixels only. It also flags which window centres are fully populated, and reports frame start/done and line-length errors to the downstream 3x3 filters (Sobel, median, etc.).

## Interface
Parameters:
- IMG_W_MAX, 1936: maximum pixels per line; must equal the line buffer's RAM depth.
- IMG_H_MAX, 1096: maximum lines per frame.
- CNT_W, 11: width of the column and row counters. Requires 2^CNT_W > max(IMG_W_MAX, IMG_H_MAX).

Ports:
- clock, in, 1: pixel clock; single clock domain.
- rst_n, in, 1: asynchronous, active-low reset.
- per_frame_vsync, in, 1: frame sync, active high. Its rising edge marks the frame boundary.
- per_frame_href, in, 1: line valid, active high.
- per_frame_clken, in, 1: pixel strobe.
- buf_clken, out, 1: clock enable to the line buffer. Asserts only for accepted pixels.
- buf_addr_clr, out, 1: one-cycle pulse that returns the line-buffer address counter to 0 before the first pixel of each line.
- col_cnt, out, CNT_W: column index of the current accepted pixel (0-based).
- row_cnt, out, CNT_W: row index of the current line (0-based).
- win_valid, out, 1: the 3x3 window centred at the output pixel is fully populated.
- frame_start, out, 1: one-cycle pulse at the start of a frame.
- frame_done, out, 1: one-cycle pulse at the end of a completed frame.
- line_len, out, CNT_W: pixel count of row 0 of the current frame.
- err_ovf, out, 1: sticky overflow error.
- err_len, out, 1: sticky line-length mismatch error.

## Operation
- Input sync is edge-detected through one register stage: vs_r, hr_r. vs_rise = vsync & ~vs_r; hr_fall = ~href & hr_r.
- An accepted pixel is one where state==LINE, href=1, clken=1 and col_cnt < IMG_W_MAX.
- State IDLE:
  - Ignore href and clken.
  - On vs_rise: clear row, col and line_len; pulse frame_start; go to FWAIT.
- State FWAIT (in frame, between lines):
  - href rising -> LINE and pulse buf_addr_clr in the same cycle.
  - vs_rise -> pulse frame_done if row_cnt>0, then restart the frame exactly as from IDLE (counters cleared, frame_start pulsed, stay FWAIT).
- State LINE:
  - Each accepted pixel increments col.
  - clken with col_cnt == IMG_W_MAX: pixel dropped, buf_clken stays low, err_ovf set.
  - On hr_fall: go to FWAIT.
    - If row==0, latch line_len = col.
    - Otherwise, if col != line_len, set err_len.
    - col cleared to 0; row += 1.
  - If row reaches IMG_H_MAX on hr_fall: set err_ovf, hold row at IMG_H_MAX-1, and keep accepting lines, which overwrite that row.
  - vs_rise while in LINE:
    - Line aborted: no row increment, no length check.
    - frame_done pulses only if row_cnt>0.
    - Frame restarts in FWAIT.
- win_valid = the accepted pixel's row>=2 and col>=2, i.e. the two previous lines and two previous columns exist.
  - The centre pixel is (row-1, col-1).
  - No border replication; downstream blanks invalid windows.
- Sticky errors clear only on rst_n or on frame_start.
- Simultaneous href rising and vs_rise: the frame restart wins, the line is not entered that cycle, and it enters LINE on the next href rising edge.

## Timing
- Reset values: state IDLE; every output 0. This covers buf_clken, buf_addr_clr, col_cnt, row_cnt, win_valid, frame_start, frame_done, line_len, err_ovf and err_len.
- All outputs are registered.
- frame_start, frame_done and buf_addr_clr rise 2 cycles after the triggering input edge (1 cycle for edge detect, 1 for the output register).
- buf_clken rises 1 cycle after the input clken. Input pixel data is delayed 1 cycle externally to match.
- col_cnt and row_cnt are aligned with buf_clken: they show the index of the pixel being written.
- win_valid rises 2 cycles after buf_clken, aligning with the line buffer's tap output plus the 3x3 register stage.
- buf_addr_clr precedes the first buf_clken of a line by at least 1 cycle. This requires at least 2 cycles from the href rising edge to the first clken; otherwise the first pixel is still accepted but is written at address 0.
- A reset asserted mid-line immediately forces all outputs to 0. After release, the block waits in IDLE for the next vs_rise; a partial frame is never resumed.

## Test plan
- 8x4 frame, continuous clken, gaps of 4 cycles:
  - 32 buf_clken pulses and 4 buf_addr_clr pulses.
  - line_len=8, row_cnt counts 0..3.
  - win_valid asserts for 6x2=12 pixels.
  - frame_done pulses once at the next vsync rising edge; no errors.
- clken toggled 1-of-3 within a 16-pixel line:
  - col_cnt advances only on strobes and ends at 15.
  - buf_clken count = 16 per line.
- Row 2 of 12-pixel lines carries 11 pixels:
  - err_len=1 after that line's hr_fall and stays set.
  - Cleared by the next frame_start.
- With IMG_W_MAX=16, drive a 20-pixel line:
  - Pixels 16..19 are dropped and err_ovf=1.
  - col_cnt holds at 15; line_len=16.
- vsync rising at pixel 5 of row 3:
  - frame_done pulses with row_cnt=3, then frame_start pulses.
  - Counters restart at 0 and there is no err_len.
- rst_n pulled low during row 1 and released mid-frame:
  - All outputs are 0 during reset.
  - href is ignored until the next vsync rising edge, then a normal frame runs.
